mpc_mvmult_row_mac: RTL
=======================

Name: mpc_mvmult_row_mac

Overview:
- Downstream consumer of one H-matrix row coefficient ROM (18-bit signed, 16 fractional bits, 1-cycle synchronous read with ce0).
- Computes one dot product y = sum H[i]*v[i] over N_ELEM entries, for the ADMM QP iteration.
- Drives the ROM and vector-buffer read ports, pipelines multiply/accumulate, and returns a saturated 32-bit fixed-point result with a start/done handshake.

Parameters:
- COEF_W, 18, ROM coefficient width (signed, FRAC_BITS fractional).
- VEC_W, 32, vector element and result width (signed, FRAC_BITS fractional).
- FRAC_BITS, 16, fractional bits shared by coefficient, vector and result.
- ACC_W, 48, accumulator width (signed).
- N_ELEM, 24, elements per row.
- ADDR_W, 5, ROM/vector address width; must satisfy 2^ADDR_W >= N_ELEM.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin one row product; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; y_out valid from this cycle on
- y_out  out  VEC_W  result; held until the next done
- coef_address0  out  ADDR_W  ROM address
- coef_ce0  out  1  ROM read enable
- coef_q0  in  COEF_W  ROM data, valid 1 cycle after ce0
- vec_address0  out  ADDR_W  vector buffer address, always equal to coef_address0
- vec_ce0  out  1  vector buffer read enable, always equal to coef_ce0
- vec_q0  in  VEC_W  vector data, valid 1 cycle after ce0

Behaviour:
- Reset values: busy=0, done=0, y_out=0, ce0 outputs=0, addresses=0, accumulator=0, FSM=IDLE.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE -> ISSUE when start=1. Accumulator is cleared on the same edge.
  - ISSUE: ce0=1, address = index counter 0..N_ELEM-1, one address per cycle. Goes to DRAIN after index N_ELEM-1 is issued.
  - DRAIN: ce0=0. Waits for the pipeline to empty (2 cycles).
  - DONE: done=1 for one cycle, y_out registered, then back to IDLE.
- Pipeline: S1 address issue; S2 ROM/vector data returned; S3 product register p = coef*vec (COEF_W+VEC_W bits, signed); S4 acc += p >>> FRAC_BITS (arithmetic shift, i.e. truncation toward -inf).
- Each stage carries a valid bit. Only valid beats accumulate; no bubbles are inserted in ISSUE.
- Latency: start sampled at edge k -> addresses in cycles k+1..k+N_ELEM -> done high in cycle k+N_ELEM+3 (k+27 at defaults). Back-to-back: the next start is accepted at the DONE->IDLE return edge at the earliest.
- Accumulator: ACC_W signed, wraps internally (no overflow detection inside acc). Final conversion to VEC_W is governed by the optional feature.
- start while busy: ignored, not queued.
- reset mid-operation: immediate return to IDLE on the next edge. All outputs take their reset values, including y_out=0 and ce0=0; any in-flight beats are discarded.
- Addresses never exceed N_ELEM-1. The counter does not wrap past N_ELEM-1.
- start and reset high together: reset wins.

Optional Feature:
- Macro: MPC_MVMULT_SAT_EN.
- Defined: y_out = accumulator clamped to [-2^(VEC_W-1), 2^(VEC_W-1)-1].
- Undefined: y_out = low VEC_W bits of the accumulator (two's-complement wrap). Saves the comparator logic.

Decomposition:
- Shared package mpc_mvmult_pkg holds:
  - width constants COEF_W, VEC_W, FRAC_BITS, ACC_W;
  - the state enum {IDLE, ISSUE, DRAIN, DONE};
  - the saturation limit constants.
- One natural sub-module: mpc_mac_stage. It implements S3/S4: registered signed multiply, shift, accumulate, valid propagation and clear. The top level holds the FSM, address counter and output register.

Test Plan:
- Coef ROM uses the production row with 1.0 (0x10000) at index 17 and -1.0 (0x30000) at index 21. v[17]=0x00050000, v[21]=0x00020000, all others 0. start pulse -> done at cycle k+27, y_out=0x00030000.
- All coef=0x10000, all v=0x00010000 -> y_out=0x00180000 (24.0). busy high for cycles k+1..k+26. Exactly 24 ce0 cycles with addresses 0..23 in order.
- All coef=0x0FFFF, all v=0x7FFFFFFF -> with MPC_MVMULT_SAT_EN y_out=0x7FFFFFFF; without it y_out equals the low 32 bits of the exact 48-bit sum.
- Negative truncation: coef=0x3FFFF (-2^-16) at index 0, v[0]=0x00000001, others 0 -> y_out=0xFFFFFFFF (-1 LSB).
- start re-asserted on every cycle while busy -> exactly one done per row, and the second row begins only after IDLE is re-entered.
- reset asserted at cycle k+10 -> next cycle busy=0, ce0=0, y_out=0. A new start then yields the correct result with no residue from the aborted row.

Source files
------------

// File: rtl/mpc_mvmult_pkg.sv
// Shared widths, FSM encoding and saturation limits for the H-row dot-product engine.
package mpc_mvmult_pkg;

  localparam int COEF_W    = 18;
  localparam int VEC_W     = 32;
  localparam int FRAC_BITS = 16;
  localparam int ACC_W     = 48;
  localparam int N_ELEM    = 24;
  localparam int ADDR_W    = 5;
  localparam int PROD_W    = COEF_W + VEC_W;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  // Representable VEC_W range expressed at accumulator width, plus the clamped codes.
  localparam logic signed [ACC_W-1:0] ACC_SAT_MAX = {{(ACC_W-VEC_W+1){1'b0}}, {(VEC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_SAT_MIN = {{(ACC_W-VEC_W+1){1'b1}}, {(VEC_W-1){1'b0}}};
  localparam logic [VEC_W-1:0]        VEC_SAT_MAX = {1'b0, {(VEC_W-1){1'b1}}};
  localparam logic [VEC_W-1:0]        VEC_SAT_MIN = {1'b1, {(VEC_W-1){1'b0}}};

endpackage

// File: rtl/mpc_mvmult_row_mac_if.sv
// Start/done handshake plus the coefficient-ROM and vector-buffer read ports of one row MAC.
interface mpc_mvmult_row_mac_if;
  import mpc_mvmult_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic [VEC_W-1:0]  y_out;
  logic [ADDR_W-1:0] coef_address0;
  logic              coef_ce0;
  logic [COEF_W-1:0] coef_q0;
  logic [ADDR_W-1:0] vec_address0;
  logic              vec_ce0;
  logic [VEC_W-1:0]  vec_q0;

  // master: the MAC engine, which masters both memory read ports.
  modport master (
    input  start, coef_q0, vec_q0,
    output busy, done, y_out, coef_address0, coef_ce0, vec_address0, vec_ce0
  );

  // slave: the surrounding controller and memories.
  modport slave (
    output start, coef_q0, vec_q0,
    input  busy, done, y_out, coef_address0, coef_ce0, vec_address0, vec_ce0
  );

endinterface

// File: rtl/mpc_mac_stage.sv
// Product register (S3) and accumulator (S4) with final VEC_W conversion.
// Clamping to the VEC_W range is enabled by defining MPC_MVMULT_SAT_EN; otherwise the result wraps.
module mpc_mac_stage
  import mpc_mvmult_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     valid_i,
  input  logic signed [COEF_W-1:0] coef_i,
  input  logic signed [VEC_W-1:0]  vec_i,
  output logic [VEC_W-1:0]         result_d_o
);

  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic                     prod_vld_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    prod_d = PROD_W'(coef_i) * PROD_W'(vec_i);
    acc_d  = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (prod_vld_q) begin
      // Arithmetic shift drops the extra fraction, rounding toward -inf.
      acc_d = acc_q + ACC_W'(prod_q >>> FRAC_BITS);
    end
  end

  always_comb begin
    result_d_o = acc_d[VEC_W-1:0];
`ifdef MPC_MVMULT_SAT_EN
    if (acc_d > ACC_SAT_MAX) begin
      result_d_o = VEC_SAT_MAX;
    end else if (acc_d < ACC_SAT_MIN) begin
      result_d_o = VEC_SAT_MIN;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      prod_q     <= prod_d;
      prod_vld_q <= valid_i;
      acc_q      <= acc_d;
    end
  end

endmodule

// File: rtl/mpc_mvmult_row_mac.sv
// One H-row dot product: issues N_ELEM ROM/vector reads, drains the MAC pipeline, returns y_out.
// Output conversion saturates when MPC_MVMULT_SAT_EN is defined (see mpc_mac_stage).
module mpc_mvmult_row_mac
  import mpc_mvmult_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  mpc_mvmult_row_mac_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ELEM - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              drain_q, drain_d;
  logic              rd_vld_q;
  logic [VEC_W-1:0]  y_q, y_d;
  logic              acc_clear;
  logic [VEC_W-1:0]  result_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    drain_d   = drain_q;
    y_d       = y_q;
    acc_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = ISSUE;
          idx_d     = '0;
          acc_clear = 1'b1;
        end
      end
      ISSUE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
          idx_d   = '0;
          drain_d = 1'b0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        // Second drain cycle: the last beat accumulates on this edge, so capture its result.
        if (drain_q) begin
          state_d = DONE;
          drain_d = 1'b0;
          y_d     = result_d;
        end else begin
          drain_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      drain_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      rd_vld_q <= bus.coef_ce0;
      y_q      <= y_d;
    end
  end

  assign bus.coef_ce0      = (state_q == ISSUE);
  assign bus.vec_ce0       = bus.coef_ce0;
  assign bus.coef_address0 = idx_q;
  assign bus.vec_address0  = idx_q;
  assign bus.busy          = (state_q == ISSUE) || (state_q == DRAIN);
  assign bus.done          = (state_q == DONE);
  assign bus.y_out         = y_q;

  mpc_mac_stage u_mac (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (acc_clear),
    .valid_i    (rd_vld_q),
    .coef_i     ($signed(bus.coef_q0)),
    .vec_i      ($signed(bus.vec_q0)),
    .result_d_o (result_d)
  );

endmodule
